// File: rtl/sm_bram_arbiter.sv
// Two-requester round-robin arbiter in front of the single score BRAM port.
// Optional stall counters are built only when SM_ARB_PERF_EN is defined.
module sm_bram_arbiter #(
  parameter int unsigned DATA_W    = 1024,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic              i_req0_we,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic              i_req1_we,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_rsp0_valid,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_bram_en,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  input  logic [DATA_W-1:0] i_bram_rdata,
  output logic [31:0]       o_stall_cnt0,
  output logic [31:0]       o_stall_cnt1
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state;
  logic [BW-1:0]     beats;
  logic              ptr;
  logic              gnt_v;
  logic              gnt_id;
  logic              own;
  logic              valid_x;
  logic              valid_y;
  logic              same_owner;
  logic              cmd_rd_v;
  logic              cmd_rd_id;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_id;

  // Grant depends only on valids and arbiter state, never on ready.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_id  = 1'b0;
    own     = (state == OWN1);
    valid_x = own ? i_req1_valid : i_req0_valid;
    valid_y = own ? i_req0_valid : i_req1_valid;
    if (state == IDLE) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt_v  = 1'b1;
        gnt_id = ptr;
      end else if (i_req0_valid || i_req1_valid) begin
        gnt_v  = 1'b1;
        gnt_id = i_req1_valid;
      end
    end else if (valid_x && !((beats == BW'(MAX_BURST)) && valid_y)) begin
      gnt_v  = 1'b1;
      gnt_id = own;
    end else if (valid_y) begin
      gnt_v  = 1'b1;
      gnt_id = !own;
    end
  end

  assign o_req0_ready = gnt_v && !gnt_id && i_req0_valid;
  assign o_req1_ready = gnt_v &&  gnt_id && i_req1_valid;
  assign same_owner   = (state == OWN0 && !gnt_id) || (state == OWN1 && gnt_id);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      beats        <= '0;
      ptr          <= 1'b0;
      o_bram_en    <= 1'b0;
      o_bram_we    <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_wdata <= '0;
      cmd_rd_v     <= 1'b0;
      cmd_rd_id    <= 1'b0;
    end else if (gnt_v) begin
      state <= gnt_id ? OWN1 : OWN0;
      if (!same_owner)
        beats <= BW'(1);
      else if (beats != BW'(MAX_BURST))
        beats <= beats + 1'b1;
      ptr          <= !gnt_id;
      o_bram_en    <= 1'b1;
      o_bram_we    <= gnt_id ? i_req1_we    : i_req0_we;
      o_bram_addr  <= gnt_id ? i_req1_addr  : i_req0_addr;
      o_bram_wdata <= gnt_id ? i_req1_wdata : i_req0_wdata;
      cmd_rd_v     <= !(gnt_id ? i_req1_we : i_req0_we);
      cmd_rd_id    <= gnt_id;
    end else begin
      state     <= IDLE;
      beats     <= '0;
      o_bram_en <= 1'b0;
      o_bram_we <= 1'b0;
      cmd_rd_v  <= 1'b0;
    end
  end

  // The registered command stage is the first tag stage; RD_LAT more follow the BRAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= cmd_rd_v;
      pipe_id[0] <= cmd_rd_id;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign o_rsp0_valid = pipe_v[RD_LAT-1] && !pipe_id[RD_LAT-1];
  assign o_rsp1_valid = pipe_v[RD_LAT-1] &&  pipe_id[RD_LAT-1];
  assign o_rsp_rdata  = i_bram_rdata;

`ifdef SM_ARB_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt0 <= '0;
      o_stall_cnt1 <= '0;
    end else begin
      if (i_req0_valid && !o_req0_ready && (o_stall_cnt0 != '1))
        o_stall_cnt0 <= o_stall_cnt0 + 1'b1;
      if (i_req1_valid && !o_req1_ready && (o_stall_cnt1 != '1))
        o_stall_cnt1 <= o_stall_cnt1 + 1'b1;
    end
  end
`else
  assign o_stall_cnt0 = '0;
  assign o_stall_cnt1 = '0;
`endif

endmodule

// File: tb/tb_sm_bram_arbiter.sv
// Directed bench for sm_bram_arbiter with a behavioural BRAM of RD_LAT latency.
module tb_sm_bram_arbiter;

  localparam int unsigned DATA_W    = 1024;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned MAX_BURST = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              v0, v1, rdy0, rdy1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              rsp0, rsp1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;
  logic [31:0]       stall0, stall1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  sm_bram_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_we(we0),
    .i_req0_addr(addr0), .i_req0_wdata(wd0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_we(we1),
    .i_req1_addr(addr1), .i_req1_wdata(wd1),
    .o_rsp0_valid(rsp0), .o_rsp1_valid(rsp1), .o_rsp_rdata(rsp_rdata),
    .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
    .o_bram_wdata(bram_wdata), .i_bram_rdata(bram_rdata),
    .o_stall_cnt0(stall0), .o_stall_cnt1(stall1)
  );

  function automatic logic [DATA_W-1:0] pattern(input int unsigned a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | a;
    return {32{w}};
  endfunction

  logic [DATA_W-1:0] mem     [16];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 16; a++) mem[a] <= pattern(a);
    end else if (bram_en && bram_we) begin
      mem[bram_addr] <= bram_wdata;
    end
    if (bram_en && !bram_we) rd_pipe[0] <= mem[bram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RD_LAT-1];

  task automatic clear_inputs();
    v0 = 0; v1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1; clear_inputs();
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({bram_en, bram_we, rsp0, rsp1, rdy0, rdy1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 000000", {bram_en, bram_we, rsp0, rsp1, rdy0, rdy1});
    end
    vectors++;
    if (bram_addr !== '0 || bram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got addr %0h wdata[31:0] %0h expected 0", bram_addr, bram_wdata[31:0]);
    end
    vectors++;
    if (stall0 !== 32'd0 || stall1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d/%0d expected 0/0", stall0, stall1);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    v1 = 1; we1 = 0; addr1 = 4'd3;
    @(negedge clk);
    vectors++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
      errors++; $display("FAIL sr_ready: got %b%b expected 01", rdy0, rdy1);
    end
    @(posedge clk); #1 v1 = 0;
    @(negedge clk);
    vectors++;
    if (bram_en !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 4'd3 || rsp1 !== 1'b0) begin
      errors++;
      $display("FAIL sr_cmd: got en %b we %b addr %0d rsp1 %b expected 1 0 3 0", bram_en, bram_we, bram_addr, rsp1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (rsp1 !== 1'b1 || rsp0 !== 1'b0 || rsp_rdata !== pattern(3)) begin
      errors++;
      $display("FAIL sr_rsp: got rsp %b%b data %0h expected 01 %0h", rsp0, rsp1, rsp_rdata[31:0], 32'hC0DE_0003);
    end
    vectors++;
    if (bram_en !== 1'b0) begin
      errors++; $display("FAIL sr_idle_en: got %b expected 0", bram_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (rsp1 !== 1'b0 || rsp0 !== 1'b0) begin
      errors++; $display("FAIL sr_rsp_end: got %b%b expected 00", rsp0, rsp1);
    end
  endtask

  task automatic test_round_robin();
    bit e0, er0;
    do_reset();
    v0 = 1; we0 = 0; addr0 = 4'd1;
    v1 = 1; we1 = 0; addr1 = 4'd2;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      e0 = ((c / 12) % 2) == 0;
      vectors++;
      if (rdy0 !== e0 || rdy1 !== !e0) begin
        errors++; $display("FAIL rr_ready c=%0d: got %b%b expected %b%b", c, rdy0, rdy1, e0, !e0);
      end
      if (c >= 1) begin
        vectors++;
        if (bram_en !== 1'b1 || bram_addr !== ((((c - 1) / 12) % 2) == 0 ? 4'd1 : 4'd2)) begin
          errors++; $display("FAIL rr_cmd c=%0d: got en %b addr %0d", c, bram_en, bram_addr);
        end
      end
      if (c >= 1 + RD_LAT) begin
        er0 = (((c - 1 - RD_LAT) / 12) % 2) == 0;
        vectors++;
        if (rsp0 !== er0 || rsp1 !== !er0) begin
          errors++; $display("FAIL rr_rsp c=%0d: got %b%b expected %b%b", c, rsp0, rsp1, er0, !er0);
        end
      end
      if (c == 12) begin
        vectors++;
`ifdef SM_ARB_PERF_EN
        if (stall0 !== 32'd0 || stall1 !== 32'd12) begin
          errors++; $display("FAIL rr_stall: got %0d/%0d expected 0/12", stall0, stall1);
        end
`else
        if (stall0 !== 32'd0 || stall1 !== 32'd0) begin
          errors++; $display("FAIL rr_stall: got %0d/%0d expected 0/0", stall0, stall1);
        end
`endif
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_write_burst();
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    do_reset();
    pa = '0; pd = '0;
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        v1 = 1; we1 = 1;
        addr1 = ADDR_W'(i < 12 ? i : i - 12);
        wd1 = {32{32'(i) + 32'h5000}};
      end else begin
        v1 = 0; we1 = 0;
      end
      @(negedge clk);
      if (i < 20) begin
        vectors++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
          errors++; $display("FAIL wb_ready i=%0d: got %b%b expected 01", i, rdy0, rdy1);
        end
      end
      if (i > 0) begin
        vectors++;
        if (bram_en !== 1'b1 || bram_we !== 1'b1 || bram_addr !== pa || bram_wdata !== pd) begin
          errors++;
          $display("FAIL wb_cmd i=%0d: got en %b we %b addr %0d wd %0h expected 1 1 %0d %0h",
                   i, bram_en, bram_we, bram_addr, bram_wdata[31:0], pa, pd[31:0]);
        end
      end
      pa = addr1; pd = wd1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++;
    if (bram_en !== 1'b0 || bram_we !== 1'b0) begin
      errors++; $display("FAIL wb_end: got en %b we %b expected 0 0", bram_en, bram_we);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      if (i < 5) begin
        v0 = 1; we0 = 0; addr0 = ADDR_W'(i);
      end else if (i == 5) begin
        v0 = 0; v1 = 1; we1 = 0; addr1 = 4'd9;
      end else begin
        v1 = 0;
      end
      @(negedge clk);
      if (i < 5) begin
        vectors++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
          errors++; $display("FAIL ho_own0 i=%0d: got %b%b expected 10", i, rdy0, rdy1);
        end
      end else if (i == 5) begin
        vectors++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
          errors++; $display("FAIL ho_grant1: got %b%b expected 01", rdy0, rdy1);
        end
      end
      if (i >= 1) begin
        vectors++;
        if (bram_en !== 1'b1 || bram_addr !== (i == 6 ? 4'd9 : ADDR_W'(i - 1))) begin
          errors++; $display("FAIL ho_cmd i=%0d: got en %b addr %0d", i, bram_en, bram_addr);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    logic [DATA_W-1:0] a5;
    bit exp;
    a5 = {128{8'hA5}};
    do_reset();
    v1 = 1; we1 = 1; addr1 = 4'd7; wd1 = a5;
    @(negedge clk);
    vectors++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL raw_wr_ready: got %b expected 1", rdy1);
    end
    @(posedge clk); #1 we1 = 0; wd1 = '0;
    @(negedge clk);
    vectors++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL raw_rd_ready: got %b expected 1", rdy1);
    end
    @(posedge clk); #1 v1 = 0;
    for (int k = 2; k <= 3 + RD_LAT; k++) begin
      @(negedge clk);
      exp = (k == 2 + RD_LAT);
      vectors++;
      if (rsp1 !== exp || rsp0 !== 1'b0) begin
        errors++; $display("FAIL raw_rsp k=%0d: got %b%b expected 0%b", k, rsp0, rsp1, exp);
      end
      if (exp) begin
        vectors++;
        if (rsp_rdata !== a5) begin
          errors++; $display("FAIL raw_data: got %0h expected a5a5a5a5", rsp_rdata[31:0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    v0 = 1; we0 = 0; addr0 = 4'd2;
    @(negedge clk);
    vectors++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL mf_ready: got %b expected 1", rdy0);
    end
    @(posedge clk); #1 v0 = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({rsp0, rsp1, bram_en, bram_we} !== 4'b0 || bram_addr !== '0 || bram_wdata !== '0) begin
        errors++;
        $display("FAIL mf_clear k=%0d: got rsp %b%b en %b we %b addr %0d expected all 0",
                 k, rsp0, rsp1, bram_en, bram_we, bram_addr);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (stall0 !== 32'd0 || stall1 !== 32'd0) begin
      errors++; $display("FAIL mf_stall: got %0d/%0d expected 0/0", stall0, stall1);
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_burst();
    test_handoff();
    test_raw();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
